sram_ctrl: RTL and testbench
============================

// Module: sram_ctrl
// PURPOSE
//  CPU-side responder for the external async 16-bit SRAM. It accepts one memory request at a
//  time over a valid/ready handshake and sequences the SRAM pins with wait-stated read,
//  write-pulse and bus-turnaround timing. On completion it returns a one-cycle response.
//  Sits between the memory-bus request path and the SRAM pads, on the SRAM side of the
//  on-chip/external RAM selection.
// PARAMETERS
//  ADDR_W   18  SRAM word-address width
//  RD_WAIT  2   cycles CE/OE held active per read (>=1)
//  WR_WAIT  2   cycles WE_n held low per write (>=1)
//  TURN     1   idle cycles after a write before the next request is accepted (>=0)
// PORTS
//  clk        in    1       system clock, all state on rising edge
//  rst_n      in    1       asynchronous reset, active low
//  req_valid  in    1       request present
//  req_ready  out   1       controller can accept; handshake = req_valid & req_ready
//  req_we     in    1       1=write, 0=read
//  req_addr   in    ADDR_W  word address
//  req_wdata  in    16      write data
//  req_be     in    2       byte enables, [0]=low byte, [1]=high byte, active high
//  rsp_valid  out   1       one-cycle pulse: read data valid / write complete
//  rsp_rdata  out   16      read data, held until next read completes
//  sram_addr  out   ADDR_W  SRAM address, registered
//  sram_data  inout 16      SRAM data bus; driven only during write SETUP/PULSE/HOLD, else Z
//  sram_ce_n  out   1       chip enable, active low
//  sram_oe_n  out   1       output enable, active low
//  sram_we_n  out   1       write enable, active low
//  sram_lb_n  out   1       low-byte strobe = ~be[0] while active
//  sram_ub_n  out   1       high-byte strobe = ~be[1] while active
// BEHAVIOUR
//  Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, sram_addr=0, ce_n/oe_n/we_n/lb_n/ub_n=1, data Z.
//  States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, TURN. req_ready = (state==IDLE).
//  Accept in IDLE only. addr, we, wdata and be are latched on the accept edge; inputs are ignored
//   otherwise. A requester that is not accepted holds its request.
//  Read: cycles 1..RD_WAIT (accept edge = end of cycle 0) in RD: ce_n=0, oe_n=0, lb/ub per be.
//   sram_data is sampled on the last RD edge. rsp_valid=1 in cycle RD_WAIT+1, which is IDLE, so a new
//   request may be accepted in that same cycle. Throughput is 1 read per RD_WAIT+1 cycles.
//  Read lanes whose be bit is 0 return 0 in rsp_rdata.
//  Write: WR_SETUP at cycle 1 (ce_n=0, we_n=1, data driven, strobes per be). WR_PULSE at cycles
//   2..WR_WAIT+1 (we_n=0). WR_HOLD at cycle WR_WAIT+2 (we_n=1, data still driven). Then TURN
//   cycles (all strobes high, data Z), then IDLE.
//  Write ack: rsp_valid=1 in cycle WR_WAIT+3, whether that cycle is TURN or IDLE.
//  oe_n is never low while sram_data is driven. we_n is never low outside WR_PULSE.
//  Outside active cycles: ce_n, oe_n, we_n, lb_n and ub_n are all 1. sram_addr holds its last value.
//  be=2'b00: the request is accepted and runs with normal timing. lb_n=ub_n=1 throughout, so no
//   byte is written. A read returns 0.
//  Wait counter: $clog2(max(RD_WAIT,WR_WAIT,TURN)+1) bits. Loaded on state entry, counts down
//   to 1, never wraps.
//  Reset asserted mid-operation: all strobes deassert and data goes Z immediately (async). The FSM
//   returns to IDLE, any pending rsp_valid is dropped, and the in-flight write may be partial.
//  TURN=0: the FSM goes WR_HOLD -> IDLE directly, with ready=1 in cycle WR_WAIT+3.
// TESTING
//  1 Read, defaults: addr=0x00123, be=11, SRAM model returns 0xBEEF -> oe_n low cycles 1-2,
//    rsp_valid in cycle 3 only, rsp_rdata=0xBEEF.
//  2 Write, defaults: addr=0x3FFFF, wdata=0xA55A, be=01 -> we_n low cycles 2-3, ub_n=1, lb_n=0,
//    data driven cycles 1-4, model low byte=0x5A, high byte unchanged, rsp_valid in cycle 5,
//    ready in cycle 6.
//  3 Write then read, with req_valid held high -> read accepted in cycle 6, never earlier. No cycle
//    has oe_n=0 with data driven.
//  4 Back-to-back reads to 0x00010/0x00011 -> second accepted in the first's rsp cycle.
//    rsp_valid in cycles 3 and 6.
//  5 be=00 read and write -> both complete with normal latency. The write leaves the model unchanged.
//    The read returns 0x0000.
//  6 rst_n pulsed low in cycle 2 of a write -> we_n, ce_n and lb/ub_n =1 and data Z within the same
//    cycle. No rsp_valid. After release, ready=1 and a fresh read works.

Source files
------------

// File: rtl/sram_ctrl.sv
// sram_ctrl: CPU-side responder for an external asynchronous 16-bit SRAM.
//
// Takes one request at a time over a valid/ready handshake and sequences the
// SRAM pins with a wait-stated read, a setup/pulse/hold write, and optional
// bus-turnaround idle cycles after each write. A one-cycle rsp_valid pulse
// reports read data or write completion.
//
// Ports
//   clk        in     system clock, all state on the rising edge
//   rst_n      in     asynchronous reset, active low
//   req_valid  in     request present
//   req_ready  out    controller idle and able to accept
//   req_we     in     1 = write, 0 = read
//   req_addr   in     SRAM word address
//   req_wdata  in     write data
//   req_be     in     byte enables, [0] low byte, [1] high byte
//   rsp_valid  out    one-cycle pulse: read data valid / write complete
//   rsp_rdata  out    read data, held until the next read completes
//   sram_addr  out    registered SRAM address
//   sram_data  inout  SRAM data bus, driven only during the write phases
//   sram_ce_n  out    chip enable, active low
//   sram_oe_n  out    output enable, active low
//   sram_we_n  out    write enable, active low
//   sram_lb_n  out    low-byte strobe, active low
//   sram_ub_n  out    high-byte strobe, active low
module sram_ctrl #(
  parameter int ADDR_W  = 18,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2,
  parameter int TURN    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  input  logic [1:0]        req_be,
  output logic              rsp_valid,
  output logic [15:0]       rsp_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [15:0]       sram_data,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n
);

  localparam int MAX_RW = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int MAX_W  = (MAX_RW > TURN) ? MAX_RW : TURN;
  localparam int CW     = (MAX_W < 1) ? 1 : $clog2(MAX_W + 1);

  localparam logic [CW-1:0] RD_LOAD   = CW'(RD_WAIT);
  localparam logic [CW-1:0] WR_LOAD   = CW'(WR_WAIT);
  localparam logic [CW-1:0] TURN_LOAD = CW'(TURN);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_TURN
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          be_q, be_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [15:0]         rdata_q, rdata_d;

  logic                active;
  logic                drive_data;
  logic [15:0]         lane_mask;

  // State and control registers; strobes derive from state_q so an async
  // reset releases the SRAM pins immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      be_q        <= 2'b00;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 16'h0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  // Write data only matters while a write phase drives the bus.
  always_ff @(posedge clk) begin
    wdata_q <= wdata_d;
  end

  assign lane_mask = {{8{be_q[1]}}, {8{be_q[0]}}};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          be_d    = req_be;
          wdata_d = req_wdata;
          if (req_we) begin
            state_d = S_WR_SETUP;
          end else begin
            state_d = S_RD;
            cnt_d   = RD_LOAD;
          end
        end
      end
      S_RD: begin
        if (cnt_q <= CNT_ONE) begin
          // Last read edge: capture the bus, zeroing disabled lanes.
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rdata_d     = sram_data & lane_mask;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_WR_SETUP: begin
        state_d = S_WR_PULSE;
        cnt_d   = WR_LOAD;
      end
      S_WR_PULSE: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = S_WR_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_WR_HOLD: begin
        // The write ack lands in the first cycle after hold, whether that
        // cycle is turnaround or already idle.
        rsp_valid_d = 1'b1;
        if (TURN == 0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_TURN;
          cnt_d   = TURN_LOAD;
        end
      end
      S_TURN: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pin decode. TURN and IDLE are inactive: every strobe high, bus released.
  always_comb begin
    active     = 1'b0;
    drive_data = 1'b0;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    case (state_q)
      S_RD: begin
        active    = 1'b1;
        sram_oe_n = 1'b0;
      end
      S_WR_SETUP, S_WR_HOLD: begin
        active     = 1'b1;
        drive_data = 1'b1;
      end
      S_WR_PULSE: begin
        active     = 1'b1;
        drive_data = 1'b1;
        sram_we_n  = 1'b0;
      end
      default: begin
        active = 1'b0;
      end
    endcase
  end

  assign sram_ce_n = ~active;
  assign sram_lb_n = ~(active & be_q[0]);
  assign sram_ub_n = ~(active & be_q[1]);
  assign sram_data = drive_data ? wdata_q : 16'hzzzz;

  assign sram_addr = addr_q;
  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: bench for sram_ctrl with a behavioural SRAM on the pins,
// a directed vector table, a reset-during-write sequence and randomized
// transactions checked against a word-level reference memory.
module tb_sram_ctrl;

  localparam int AW     = 18;
  localparam int R      = 2;
  localparam int W      = 2;
  localparam int T      = 1;
  localparam int RD_END = R + 1;
  localparam int WR_END = W + 3 + T;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [15:0]   req_wdata = 16'h0;
  logic [1:0]    req_be = 2'b00;
  logic          req_ready;
  logic          rsp_valid;
  logic [15:0]   rsp_rdata;
  logic [AW-1:0] sram_addr;
  wire  [15:0]   sram_data;
  logic          sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

  sram_ctrl #(.ADDR_W(AW), .RD_WAIT(R), .WR_WAIT(W), .TURN(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
    logic [1:0]    be;
    int            mode;   // 0: idle after, 1: next presented in rsp cycle, 2: next held from cycle 1
    logic [15:0]   exp;    // read: expected rdata; write: expected word afterwards
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // ---------------- SRAM pin model and reference memory ----------------
  function automatic logic [15:0] init_word(input int a);
    return a[15:0] ^ 16'hC3C3;
  endfunction

  logic [15:0] smem [int];
  logic [15:0] rmem [int];

  function automatic logic [15:0] model_rd(input int a);
    return smem.exists(a) ? smem[a] : init_word(a);
  endfunction

  function automatic logic [15:0] ref_rd(input int a);
    return rmem.exists(a) ? rmem[a] : init_word(a);
  endfunction

  logic [15:0] model_q = 16'h0;
  wire         model_drive = !sram_ce_n && !sram_oe_n && sram_we_n;
  assign sram_data = model_drive ? model_q : 16'hzzzz;

  always @(negedge clk) begin
    logic [15:0] w;
    model_q = model_rd(int'(sram_addr));
    if (!sram_ce_n && !sram_we_n) begin
      w = model_rd(int'(sram_addr));
      if (!sram_lb_n) w[7:0]  = sram_data[7:0];
      if (!sram_ub_n) w[15:8] = sram_data[15:8];
      smem[int'(sram_addr)] = w;
    end
  end

  // ---------------- expected pin timeline from the cycle rules ----------------
  // Packed as {ready, rsp_valid, ce_n, oe_n, we_n, lb_n, ub_n}; k = cycles after accept.
  function automatic logic [6:0] exp_pins(input bit wr, input logic [1:0] be, input int k);
    logic rdy, rsp, ce, oe, wen, lb, ub;
    rdy = 1'b0; rsp = 1'b0; ce = 1'b1; oe = 1'b1; wen = 1'b1; lb = 1'b1; ub = 1'b1;
    if (!wr) begin
      if (k <= R) begin
        ce = 1'b0; oe = 1'b0; lb = !be[0]; ub = !be[1];
      end else begin
        rdy = 1'b1; rsp = 1'b1;
      end
    end else begin
      if (k <= W + 2) begin
        ce = 1'b0; lb = !be[0]; ub = !be[1];
        wen = !(k >= 2 && k <= W + 1);
      end
      rsp = (k == W + 3);
      rdy = (k == WR_END);
    end
    return {rdy, rsp, ce, oe, wen, lb, ub};
  endfunction

  task automatic drive(input vec_t v, input bit valid);
    req_valid = valid;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_be    = v.be;
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    v.we    = 1'($urandom);
    v.addr  = AW'($urandom);
    v.wdata = 16'($urandom);
    v.be    = 2'($urandom);
    v.mode  = 0;
    v.exp   = 16'h0;
    return v;
  endfunction

  logic [15:0] last_rd = 16'h0;
  bit          presented = 1'b0;

  task automatic run_txn(input vec_t t, input vec_t nxt, output logic [15:0] got);
    int endk;
    logic [15:0] rw;
    endk = t.we ? WR_END : RD_END;
    if (!presented) begin
      @(posedge clk); #1;
      drive(t, 1'b1);
      @(negedge clk);
      chk("accept ready", 32'(req_ready), 32'd1);
    end
    presented = 1'b0;
    for (int k = 1; k <= endk; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        if (t.mode == 2) drive(nxt, 1'b1);
        else drive(rand_vec(), 1'b0);
      end
      if (k == endk && t.mode == 1) drive(nxt, 1'b1);
      @(negedge clk);
      chk($sformatf("%s pins k=%0d", t.we ? "wr" : "rd", k),
          32'({req_ready, rsp_valid, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}),
          32'(exp_pins(t.we, t.be, k)));
      if (k == 1) chk("sram_addr", 32'(sram_addr), 32'(t.addr));
      if (t.we && k <= W + 2) chk($sformatf("wr bus k=%0d", k), 32'(sram_data), 32'(t.wdata));
    end
    if (t.we) begin
      rw = ref_rd(int'(t.addr));
      if (t.be[0]) rw[7:0]  = t.wdata[7:0];
      if (t.be[1]) rw[15:8] = t.wdata[15:8];
      rmem[int'(t.addr)] = rw;
      chk("rdata held over write", 32'(rsp_rdata), 32'(last_rd));
      chk("mem after write", 32'(model_rd(int'(t.addr))), 32'(rw));
    end else begin
      rw = ref_rd(int'(t.addr)) & {{8{t.be[1]}}, {8{t.be[0]}}};
      chk("rdata", 32'(rsp_rdata), 32'(rw));
      last_rd = rw;
    end
    got = t.we ? model_rd(int'(t.addr)) : rsp_rdata;
    presented = (t.mode != 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t        tbl [10];
  vec_t        rv  [40];
  vec_t        wv;
  logic [15:0] got;

  initial begin
    smem[32'h123]   = 16'hBEEF;  rmem[32'h123]   = 16'hBEEF;
    smem[32'h3FFFF] = 16'h1234;  rmem[32'h3FFFF] = 16'h1234;

    tbl[0] = '{1'b0, 18'h00123, 16'h0000, 2'b11, 0, 16'hBEEF};
    tbl[1] = '{1'b1, 18'h3FFFF, 16'hA55A, 2'b01, 0, 16'h125A};
    tbl[2] = '{1'b1, 18'h00200, 16'h1357, 2'b11, 2, 16'h1357};
    tbl[3] = '{1'b0, 18'h00200, 16'h0000, 2'b11, 1, 16'h1357};
    tbl[4] = '{1'b0, 18'h00010, 16'h0000, 2'b11, 1, 16'hC3D3};
    tbl[5] = '{1'b0, 18'h00011, 16'h0000, 2'b10, 0, 16'hC300};
    tbl[6] = '{1'b1, 18'h00123, 16'hFFFF, 2'b00, 0, 16'hBEEF};
    tbl[7] = '{1'b0, 18'h00123, 16'h0000, 2'b00, 0, 16'h0000};
    tbl[8] = '{1'b1, 18'h3FFFF, 16'h6699, 2'b10, 0, 16'h665A};
    tbl[9] = '{1'b0, 18'h3FFFF, 16'h0000, 2'b11, 0, 16'h665A};

    // Reset state
    #12;
    chk("reset ready", 32'(req_ready), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("reset sram_addr", 32'(sram_addr), 32'd0);
    chk("reset strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}), 32'h1F);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i], tbl[(i < 9) ? i + 1 : i], got);
      chk($sformatf("tbl[%0d] result", i), 32'(got), 32'(tbl[i].exp));
    end

    // Reset asserted during the first write-pulse cycle
    wv = '{1'b1, 18'h00300, 16'hFFFF, 2'b11, 0, 16'h0};
    @(posedge clk); #1;
    drive(wv, 1'b1);
    @(negedge clk);
    chk("rst seq accept", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    drive(rand_vec(), 1'b0);
    @(negedge clk);
    chk("rst seq setup we_n", 32'({sram_ce_n, sram_we_n}), 32'b01);
    @(posedge clk); #2;
    chk("rst seq pulse we_n", 32'(sram_we_n), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst seq strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}), 32'h1F);
    chk("rst seq ready", 32'(req_ready), 32'd1);
    chk("rst seq rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("post-rst idle %0d", i), 32'({req_ready, rsp_valid}), 32'b10);
    end
    chk("post-rst rdata", 32'(rsp_rdata), 32'd0);
    last_rd   = 16'h0;
    presented = 1'b0;
    wv = '{1'b0, 18'h00123, 16'h0000, 2'b11, 0, 16'hBEEF};
    run_txn(wv, wv, got);
    chk("post-rst read", 32'(got), 32'hBEEF);

    // Randomized traffic against the reference memory
    for (int i = 0; i < 40; i++) begin
      rv[i] = rand_vec();
      rv[i].addr = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) rv[i].addr = rv[i].addr | 18'h3FFF0;
      rv[i].mode = (i == 39) ? 0 : int'($urandom_range(0, 2));
    end
    for (int i = 0; i < 40; i++) begin
      run_txn(rv[i], rv[(i < 39) ? i + 1 : i], got);
    end

    @(posedge clk); #1;
    req_valid = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
